ascon_fsm_ctrl: RTL and testbench
=================================

Name: ascon_fsm_ctrl

Overview:
- Control FSM that sequences the ASCON-128 `permutation_xor` datapath through four phases: initialisation, associated data, plaintext and finalisation.
- Drives `round_i`, `state_mode_i`, `en_i` and every XOR/output-capture enable of that datapath, one permutation round per cycle.
- Accepts 64-bit AD/plaintext blocks from an upstream source through a valid/ready handshake, stalling the datapath while data is absent.
- Sits between the top-level `ascon` wrapper and `permutation_xor`; the `data_i`/`key_i`/`state_i` buses bypass this block.

Parameters:
NB_AD, 1, number of associated-data blocks, legal range 1..15
NB_PT, 3, number of plaintext blocks including the last padded one, legal range 1..15

Ports:
clock_i  in  1  system clock, all logic on rising edge
reset_i  in  1  synchronous, active-high reset
start_i  in  1  begin one encryption; sampled only in IDLE or DONE
data_valid_i  in  1  upstream block on `data_i` is valid
data_ready_o  out  1  controller is at a data-injection cycle
round_o  out  4  round index to datapath `round_i`
state_mode_o  out  1  0 = datapath loads `state_i`, 1 = datapath uses its state register
en_reg_state_o  out  1  datapath state register write enable (`en_i`)
en_xor_key_begin_o  out  1  key XOR before the permutation
en_xor_key_end_o  out  1  key XOR after the permutation
en_xor_lsb_o  out  1  domain-separation XOR
en_xor_data_o  out  1  data block XOR
en_out_cipher_o  out  1  cipher register capture
en_out_tag_o  out  1  tag register capture
cipher_valid_o  out  1  one-cycle pulse: datapath `cipher_o` was updated on the previous edge
tag_valid_o  out  1  one-cycle pulse: datapath `tag_o` was updated on the previous edge
busy_o  out  1  high in every state except IDLE and DONE
end_o  out  1  encryption complete; held high in DONE

Behaviour:
- Registers:
  - FSM state.
  - 4-bit round counter `cnt`.
  - 4-bit block counter `blk`.
  - `cipher_valid_o` and `tag_valid_o` flops.
- All other outputs are combinational decodes of (state, `cnt`, `blk`, `data_valid_i`). Any enable not listed for a state is 0.
- Reset: state=IDLE, `cnt`=0, `blk`=0, all outputs 0. Reset mid-operation aborts immediately with no tag; the datapath is reloaded at the next INIT.
- IDLE:
  - Outputs 0.
  - `start_i`=1 -> INIT, `cnt`=0.
- INIT:
  - `round_o`=`cnt`, `en_reg_state_o`=1, `state_mode_o`=(`cnt`!=0), `en_xor_key_end_o`=(`cnt`==11).
  - `cnt`++ each cycle.
  - At `cnt`==11 -> AD, `cnt`=6, `blk`=0.
- AD:
  - `round_o`=`cnt`, `state_mode_o`=1.
  - `cnt`==6: `data_ready_o`=1.
    - `data_valid_i`=0: `en_reg_state_o`=0, hold (stall).
    - `data_valid_i`=1: `en_xor_data_o`=1, `en_reg_state_o`=1, `cnt`=7.
  - `cnt` 7..11: `en_reg_state_o`=1, `cnt`++.
  - `cnt`==11:
    - If `blk`==NB_AD-1: `en_xor_lsb_o`=1, then -> PT (NB_PT>1, `cnt`=6, `blk`=0) or FINAL (NB_PT==1, `cnt`=0, `blk`=0).
    - Otherwise: `blk`++, `cnt`=6.
- PT (non-last blocks):
  - Same cycle pattern as AD, with `en_out_cipher_o`=1 alongside `en_xor_data_o` on the handshake cycle.
  - No LSB XOR.
  - At `cnt`==11:
    - If `blk`==NB_PT-2: -> FINAL, `cnt`=0.
    - Otherwise: `blk`++, `cnt`=6.
- FINAL:
  - `round_o`=`cnt`, `state_mode_o`=1.
  - `cnt`==0 is the handshake for the last (padded) plaintext block: `data_ready_o`=1.
    - `data_valid_i`=0: `en_reg_state_o`=0, hold.
    - `data_valid_i`=1: `en_xor_data_o`, `en_out_cipher_o`, `en_xor_key_begin_o` and `en_reg_state_o` all =1, `cnt`=1.
  - `cnt` 1..11: `en_reg_state_o`=1, `en_xor_key_end_o`=(`cnt`==11).
  - After `cnt`==11 -> TAG.
- TAG:
  - One cycle: `en_out_tag_o`=1, `en_reg_state_o`=0, `round_o`=0.
  - -> DONE.
- DONE:
  - `end_o`=1, datapath enables 0.
  - `start_i`=1 -> INIT, `cnt`=0, `end_o` drops; otherwise stay.
- `start_i` is ignored in INIT, AD, PT, FINAL and TAG.
- `cipher_valid_o`/`tag_valid_o` are the registered versions of `en_out_cipher_o`/`en_out_tag_o`; each is high for exactly one cycle.
- `data_ready_o` is never high while `data_valid_i` cannot be consumed. A transfer occurs only when both are high on the same edge.
- Latency with `data_valid_i` tied high, counted from the edge that samples `start_i`:
  - 12 INIT + 6·NB_AD + 6·(NB_PT-1) + 12 FINAL + 1 TAG cycles, then DONE.
  - Defaults: TAG in cycle 43, `end_o` high from cycle 44.
- Each stall cycle adds exactly one cycle of latency and leaves the datapath state unchanged.

Test Plan:
- Defaults, `data_valid_i`=1 always, IV/K/N state 80400c0600000000, 8a55114d1cb6a9a2, be263d4d7aecaaff, 4ed0ec0b98c529b7, c8cddf37bcd0284a; key 8a55114d1cb6a9a2be263d4d7aecaaff. Expect:
  - `en_xor_key_end_o` in cycles 12 and 42.
  - `en_xor_lsb_o` in cycle 18.
  - `en_out_cipher_o` in cycles 19, 25 and 31.
  - `en_out_tag_o` in cycle 43; `end_o` from 44.
  - Tag matches the golden model.
- Same run, `data_valid_i` low for 3 cycles at the AD handshake and 2 at the last-block handshake: `end_o` at cycle 49, `round_o` frozen at 6 and 0 respectively during the stalls, cipher/tag unchanged vs the first scenario.
- NB_AD=2, NB_PT=1: `en_xor_lsb_o` only in cycle 24, not cycle 18; `en_out_cipher_o` once, in cycle 25; `end_o` from cycle 38.
- `reset_i` asserted in PT cycle 22: next cycle all outputs 0 and `busy_o`=0; `start_i` after release reruns the first scenario with identical results.
- `start_i` pulsed during FINAL: ignored. `start_i` in DONE: INIT begins next cycle with `state_mode_o`=0, `round_o`=0.
- Back-to-back encryptions, `start_i` held high: exactly one TAG cycle per run, `tag_valid_o` pulses exactly once each.

Source files
------------

// File: rtl/ascon_fsm_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : ascon_fsm_ctrl_if
// Description : Handshake and datapath-control bundle of the ASCON-128
//               control FSM. The master side is the controller, the slave
//               side is the upstream source plus the permutation_xor datapath.
// Revision    : 1.0 - initial release
// ============================================================================
interface ascon_fsm_ctrl_if;
  logic       start_i;
  logic       data_valid_i;
  logic       data_ready_o;
  logic [3:0] round_o;
  logic       state_mode_o;
  logic       en_reg_state_o;
  logic       en_xor_key_begin_o;
  logic       en_xor_key_end_o;
  logic       en_xor_lsb_o;
  logic       en_xor_data_o;
  logic       en_out_cipher_o;
  logic       en_out_tag_o;
  logic       cipher_valid_o;
  logic       tag_valid_o;
  logic       busy_o;
  logic       end_o;

  modport master (
    input  start_i, data_valid_i,
    output data_ready_o, round_o, state_mode_o, en_reg_state_o,
           en_xor_key_begin_o, en_xor_key_end_o, en_xor_lsb_o, en_xor_data_o,
           en_out_cipher_o, en_out_tag_o, cipher_valid_o, tag_valid_o,
           busy_o, end_o
  );

  modport slave (
    output start_i, data_valid_i,
    input  data_ready_o, round_o, state_mode_o, en_reg_state_o,
           en_xor_key_begin_o, en_xor_key_end_o, en_xor_lsb_o, en_xor_data_o,
           en_out_cipher_o, en_out_tag_o, cipher_valid_o, tag_valid_o,
           busy_o, end_o
  );
endinterface
`default_nettype wire

// File: rtl/ascon_fsm_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ascon_fsm_ctrl
// Description : Sequencer for the ASCON-128 permutation_xor datapath:
//               INIT (12 rounds), NB_AD associated-data blocks (6 rounds
//               each), NB_PT-1 plaintext blocks (6 rounds each), FINAL
//               (last padded block + 12 rounds) and one TAG capture cycle.
//               Block injection stalls until the upstream source is valid.
// Revision    : 1.0 - initial release
// ============================================================================
module ascon_fsm_ctrl #(
  parameter int NB_AD = 1,
  parameter int NB_PT = 3
) (
  input  logic               clock_i,
  input  logic               reset_i,
  ascon_fsm_ctrl_if.master   bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_AD    = 3'd2,
    S_PT    = 3'd3,
    S_FINAL = 3'd4,
    S_TAG   = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  // Block-counter values that mark the last AD block and the last
  // non-padded plaintext block (the latter unused when NB_PT == 1).
  localparam logic [3:0] C_LAST_AD = 4'(NB_AD - 1);
  localparam logic [3:0] C_LAST_PT = 4'(NB_PT - 2);
  localparam bit         C_HAS_PT  = (NB_PT > 1);

  state_t     state_q;
  logic [3:0] cnt_q;
  logic [3:0] blk_q;
  logic       cipher_valid_q;
  logic       tag_valid_q;

  logic       data_ready;
  logic [3:0] round;
  logic       state_mode;
  logic       en_reg_state;
  logic       en_xor_key_begin;
  logic       en_xor_key_end;
  logic       en_xor_lsb;
  logic       en_xor_data;
  logic       en_out_cipher;
  logic       en_out_tag;
  logic       busy;
  logic       done;

  // Decode datapath controls from state, counters and the live valid input.
  always_comb begin
    data_ready       = 1'b0;
    round            = 4'd0;
    state_mode       = 1'b0;
    en_reg_state     = 1'b0;
    en_xor_key_begin = 1'b0;
    en_xor_key_end   = 1'b0;
    en_xor_lsb       = 1'b0;
    en_xor_data      = 1'b0;
    en_out_cipher    = 1'b0;
    en_out_tag       = 1'b0;
    busy             = 1'b1;
    done             = 1'b0;
    case (state_q)
      S_INIT: begin
        round          = cnt_q;
        en_reg_state   = 1'b1;
        state_mode     = (cnt_q != 4'd0);
        en_xor_key_end = (cnt_q == 4'd11);
      end
      S_AD, S_PT: begin
        round      = cnt_q;
        state_mode = 1'b1;
        if (cnt_q == 4'd6) begin
          // Injection round: the permutation only advances with a block.
          data_ready = 1'b1;
          if (bus.data_valid_i) begin
            en_xor_data   = 1'b1;
            en_reg_state  = 1'b1;
            en_out_cipher = (state_q == S_PT);
          end
        end else begin
          en_reg_state = 1'b1;
          en_xor_lsb   = (state_q == S_AD) && (cnt_q == 4'd11) && (blk_q == C_LAST_AD);
        end
      end
      S_FINAL: begin
        round      = cnt_q;
        state_mode = 1'b1;
        if (cnt_q == 4'd0) begin
          // Last padded plaintext block, followed by the pre-permutation key XOR.
          data_ready = 1'b1;
          if (bus.data_valid_i) begin
            en_xor_data      = 1'b1;
            en_out_cipher    = 1'b1;
            en_xor_key_begin = 1'b1;
            en_reg_state     = 1'b1;
          end
        end else begin
          en_reg_state   = 1'b1;
          en_xor_key_end = (cnt_q == 4'd11);
        end
      end
      S_TAG: begin
        en_out_tag = 1'b1;
      end
      S_DONE: begin
        busy = 1'b0;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Phase sequencing, round/block counting and the capture-valid pulses.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q        <= S_IDLE;
      cnt_q          <= 4'd0;
      blk_q          <= 4'd0;
      cipher_valid_q <= 1'b0;
      tag_valid_q    <= 1'b0;
    end else begin
      cipher_valid_q <= en_out_cipher;
      tag_valid_q    <= en_out_tag;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start_i) begin
            state_q <= S_INIT;
            cnt_q   <= 4'd0;
          end
        end
        S_INIT: begin
          if (cnt_q == 4'd11) begin
            state_q <= S_AD;
            cnt_q   <= 4'd6;
            blk_q   <= 4'd0;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        S_AD: begin
          if (cnt_q == 4'd6) begin
            if (bus.data_valid_i) cnt_q <= 4'd7;
          end else if (cnt_q == 4'd11) begin
            if (blk_q == C_LAST_AD) begin
              blk_q <= 4'd0;
              if (C_HAS_PT) begin
                state_q <= S_PT;
                cnt_q   <= 4'd6;
              end else begin
                state_q <= S_FINAL;
                cnt_q   <= 4'd0;
              end
            end else begin
              blk_q <= blk_q + 4'd1;
              cnt_q <= 4'd6;
            end
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        S_PT: begin
          if (cnt_q == 4'd6) begin
            if (bus.data_valid_i) cnt_q <= 4'd7;
          end else if (cnt_q == 4'd11) begin
            if (blk_q == C_LAST_PT) begin
              state_q <= S_FINAL;
              cnt_q   <= 4'd0;
            end else begin
              blk_q <= blk_q + 4'd1;
              cnt_q <= 4'd6;
            end
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        S_FINAL: begin
          if (cnt_q == 4'd0) begin
            if (bus.data_valid_i) cnt_q <= 4'd1;
          end else if (cnt_q == 4'd11) begin
            state_q <= S_TAG;
            cnt_q   <= 4'd0;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        S_TAG: begin
          state_q <= S_DONE;
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= 4'd0;
          blk_q   <= 4'd0;
        end
      endcase
    end
  end

  assign bus.data_ready_o       = data_ready;
  assign bus.round_o            = round;
  assign bus.state_mode_o       = state_mode;
  assign bus.en_reg_state_o     = en_reg_state;
  assign bus.en_xor_key_begin_o = en_xor_key_begin;
  assign bus.en_xor_key_end_o   = en_xor_key_end;
  assign bus.en_xor_lsb_o       = en_xor_lsb;
  assign bus.en_xor_data_o      = en_xor_data;
  assign bus.en_out_cipher_o    = en_out_cipher;
  assign bus.en_out_tag_o       = en_out_tag;
  assign bus.cipher_valid_o     = cipher_valid_q;
  assign bus.tag_valid_o        = tag_valid_q;
  assign bus.busy_o             = busy;
  assign bus.end_o              = done;

endmodule
`default_nettype wire

// File: tb/tb_ascon_fsm_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ascon_fsm_ctrl
// Description : Bench for ascon_fsm_ctrl. Two instances: default (1 AD,
//               3 PT blocks) and a short one (2 AD, 1 PT block). Expected
//               control traces are built from the phase/round schedule of an
//               ASCON-128 encryption.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ascon_fsm_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ascon_fsm_ctrl_if bus0 ();
  ascon_fsm_ctrl_if bus1 ();

  ascon_fsm_ctrl #(.NB_AD(1), .NB_PT(3)) dut0 (.clock_i(clk), .reset_i(rst), .bus(bus0.master));
  ascon_fsm_ctrl #(.NB_AD(2), .NB_PT(1)) dut1 (.clock_i(clk), .reset_i(rst), .bus(bus1.master));

  int n_checks = 0;
  int n_pass   = 0;

  // Observation vector:
  // [16] ready [15:12] round [11] mode [10] en_reg [9] key_begin [8] key_end
  // [7] lsb [6] xor_data [5] out_cipher [4] out_tag [3] cipher_valid
  // [2] tag_valid [1] busy [0] end
  typedef struct {
    bit          hs;
    logic [16:0] v;
  } step_t;

  step_t q[$];

  function automatic logic [16:0] mk(input logic rdy, input logic [3:0] rnd, input logic md,
                                     input logic rg, input logic kb, input logic ke,
                                     input logic lsb, input logic xd, input logic oc,
                                     input logic ot, input logic bsy, input logic en);
    return {rdy, rnd, md, rg, kb, ke, lsb, xd, oc, ot, 1'b0, 1'b0, bsy, en};
  endfunction

  function automatic logic [16:0] rd(input int w);
    if (w == 0)
      return {bus0.data_ready_o, bus0.round_o, bus0.state_mode_o, bus0.en_reg_state_o,
              bus0.en_xor_key_begin_o, bus0.en_xor_key_end_o, bus0.en_xor_lsb_o,
              bus0.en_xor_data_o, bus0.en_out_cipher_o, bus0.en_out_tag_o,
              bus0.cipher_valid_o, bus0.tag_valid_o, bus0.busy_o, bus0.end_o};
    return {bus1.data_ready_o, bus1.round_o, bus1.state_mode_o, bus1.en_reg_state_o,
            bus1.en_xor_key_begin_o, bus1.en_xor_key_end_o, bus1.en_xor_lsb_o,
            bus1.en_xor_data_o, bus1.en_out_cipher_o, bus1.en_out_tag_o,
            bus1.cipher_valid_o, bus1.tag_valid_o, bus1.busy_o, bus1.end_o};
  endfunction

  task automatic set_in(input int w, input logic s, input logic v);
    if (w == 0) begin
      bus0.start_i      = s;
      bus0.data_valid_i = v;
    end else begin
      bus1.start_i      = s;
      bus1.data_valid_i = v;
    end
  endtask

  // Expected per-cycle schedule of one encryption (data always available).
  task automatic build(input int a, input int p);
    step_t s;
    q.delete();
    for (int r = 0; r < 12; r++) begin
      s.hs = 1'b0;
      s.v  = mk(0, 4'(r), r != 0, 1, 0, r == 11, 0, 0, 0, 0, 1, 0);
      q.push_back(s);
    end
    for (int b = 0; b < a + p - 1; b++) begin
      for (int r = 6; r < 12; r++) begin
        s.hs = (r == 6);
        s.v  = mk(r == 6, 4'(r), 1, 1, 0, 0, (b == a - 1) && (r == 11), r == 6,
                  (b >= a) && (r == 6), 0, 1, 0);
        q.push_back(s);
      end
    end
    for (int r = 0; r < 12; r++) begin
      s.hs = (r == 0);
      s.v  = mk(r == 0, 4'(r), 1, 1, r == 0, r == 11, 0, r == 0, r == 0, 0, 1, 0);
      q.push_back(s);
    end
    s.hs = 1'b0;
    s.v  = mk(0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    q.push_back(s);
  endtask

  // smode: 0 = data always valid, 1 = 3 stalls at first and 2 at last
  // handshake, 2 = random stalls, random valid elsewhere, random start noise.
  task automatic run(input int w, input int a, input int p, input int smode,
                     input bit hold, input bit chained, input string name);
    logic [16:0] exp_v, act;
    bit   prev_oc = 0, prev_ot = 0, loaded = 0, consume, v, s, done = 0;
    int   n = 0, stalls = 0, hs_idx = 0, stall_left = 0, tags = 0;
    int   nhs = a + p;
    build(a, p);
    if (!chained) begin
      @(posedge clk); #1;
      set_in(w, 1'b1, 1'b1);
    end
    while (!done && n < 400) begin
      @(posedge clk); #1;
      n++;
      consume = 0;
      if (q.size() == 0) begin
        exp_v = mk(0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        v     = 1'b1;
        s     = hold;
        done  = 1;
      end else begin
        if (q[0].hs) begin
          if (!loaded) begin
            if (smode == 1)      stall_left = (hs_idx == 0) ? 3 : (hs_idx == nhs - 1) ? 2 : 0;
            else if (smode == 2) stall_left = $urandom_range(0, 3);
            else                 stall_left = 0;
            loaded = 1;
          end
          if (stall_left > 0) begin
            v = 1'b0;
            stall_left--;
            stalls++;
            exp_v = mk(1, q[0].v[15:12], 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
          end else begin
            v       = 1'b1;
            consume = 1;
            loaded  = 0;
            hs_idx++;
            exp_v = q[0].v;
          end
        end else begin
          v       = (smode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
          consume = 1;
          exp_v   = q[0].v;
        end
        s = hold ? 1'b1 : (smode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      set_in(w, s, v);
      exp_v[3] = prev_oc;
      exp_v[2] = prev_ot;
      prev_oc  = exp_v[5];
      prev_ot  = exp_v[4];
      @(negedge clk);
      act = rd(w);
      n_checks++;
      if (act !== exp_v)
        $display("FAIL %s cycle %0d: outputs got %h expected %h", name, n, act, exp_v);
      else
        n_pass++;
      if (act[2] === 1'b1) tags++;
      if (consume) void'(q.pop_front());
    end
    n_checks++;
    if (!done || n != 12 + 6 * a + 6 * (p - 1) + 14 + stalls)
      $display("FAIL %s latency: end_o first seen in cycle %0d expected %0d",
               name, n, 12 + 6 * a + 6 * (p - 1) + 14 + stalls);
    else
      n_pass++;
    n_checks++;
    if (tags != 1)
      $display("FAIL %s tag_valid pulses: got %0d expected 1", name, tags);
    else
      n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(0, 1'b1, 1'b1);
    set_in(1, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      n_checks++;
      if (rd(w) !== 17'd0) $display("FAIL reset_hold dut%0d: got %h expected 0", w, rd(w));
      else n_pass++;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    set_in(0, 1'b0, 1'b0);
    @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      n_checks++;
      if (rd(w) !== 17'd0) $display("FAIL reset_release dut%0d: got %h expected 0", w, rd(w));
      else n_pass++;
    end
  endtask

  task automatic test_reset_midrun();
    @(posedge clk); #1;
    set_in(0, 1'b1, 1'b1);
    for (int i = 1; i <= 21; i++) begin
      @(posedge clk); #1;
      set_in(0, 1'b0, 1'b1);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (rd(0) !== mk(0, 4'd9, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0))
      $display("FAIL reset_midrun_pt22: got %h expected %h", rd(0),
               mk(0, 4'd9, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0));
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rd(0) !== 17'd0) $display("FAIL reset_midrun_after: got %h expected 0", rd(0));
    else n_pass++;
  endtask

  task automatic test_default();     run(0, 1, 3, 0, 0, 0, "default");        endtask
  task automatic test_stall();       run(0, 1, 3, 1, 0, 0, "stall");          endtask
  task automatic test_short_config(); run(1, 2, 1, 0, 0, 0, "ad2_pt1");       endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) run(0, 1, 3, 2, 0, 0, "random_dflt");
    for (int i = 0; i < 2; i++) run(1, 2, 1, 2, 0, 0, "random_short");
  endtask

  task automatic test_back_to_back();
    run(0, 1, 3, 0, 1, 0, "b2b_first");
    run(0, 1, 3, 0, 1, 1, "b2b_second");
    run(0, 1, 3, 2, 0, 1, "b2b_third");
  endtask

  initial begin
    rst = 1'b1;
    set_in(0, 1'b0, 1'b0);
    set_in(1, 1'b0, 1'b0);
    test_reset();
    test_default();
    test_stall();
    test_short_config();
    test_reset_midrun();
    test_default();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
